// File: rtl/block_ram_pkg.sv
// Shared types for the block RAM pipeline: read-during-write mode and clear FSM states.
package block_ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/block_ram_core.sv
// Storage array with byte-strobed write and a registered, enable-gated read port.
module block_ram_core
    import block_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    re_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int NB    = DATA_WIDTH / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array is deliberately left unreset; zeroing comes from the clear sweep.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/block_ram_pipe.sv
// Dual-port block RAM with clear sweep FSM, write-first collision bypass and 1/2-cycle read pipe.
module block_ram_pipe
    import block_ram_pkg::*;
#(
    parameter int        DATA_WIDTH = 32,
    parameter int        ADDR_WIDTH = 16,
    parameter int        RD_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE   = READ_FIRST
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear_req,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int NB = DATA_WIDTH / BYTE_W;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (clear_req) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb busy = (state_q == CLEAR);

    // The sweep owns the write port; user traffic is dropped while busy.
    logic                  wr_acc, rd_acc, coll;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata, core_rdata;
    logic [NB-1:0]         mem_wstrb;

    assign wr_acc    = wr_en & ~busy;
    assign rd_acc    = rd_en & ~busy;
    assign mem_we    = busy | wr_acc;
    assign mem_waddr = busy ? cnt_q : wr_addr;
    assign mem_wdata = busy ? '0 : wr_data;
    assign mem_wstrb = busy ? '1 : wr_strb;
    assign coll      = (RDW_MODE == WRITE_FIRST) && wr_acc && rd_acc && (wr_addr == rd_addr);

    block_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .wstrb_i (mem_wstrb),
        .re_i    (rd_acc),
        .raddr_i (rd_addr),
        .rdata_o (core_rdata)
    );

    logic [RD_LATENCY:1]   vld_pipe_q;
    logic                  coll_q;
    logic [DATA_WIDTH-1:0] byp_data_q, rd1_word;
    logic [NB-1:0]         byp_strb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            coll_q     <= 1'b0;
            byp_data_q <= '0;
            byp_strb_q <= '0;
        end else begin
            vld_pipe_q[1] <= rd_acc;
            for (int i = 2; i <= RD_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
            if (rd_acc) begin
                coll_q     <= coll;
                byp_data_q <= wr_data;
                byp_strb_q <= wr_strb;
            end
        end
    end

    // Core read is read-first; a captured collision patches in the strobed write bytes.
    always_comb begin
        rd1_word = core_rdata;
        if (coll_q) begin
            for (int b = 0; b < NB; b++) begin
                if (byp_strb_q[b]) rd1_word[b*BYTE_W +: BYTE_W] = byp_data_q[b*BYTE_W +: BYTE_W];
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign rd_data = rd1_word;
        end else begin : g_lat2
            logic [DATA_WIDTH-1:0] rd2_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)          rd2_q <= '0;
                else if (vld_pipe_q[1]) rd2_q <= rd1_word;
            end
            assign rd_data = rd2_q;
        end
    endgenerate

    assign rd_valid = vld_pipe_q[RD_LATENCY];

endmodule

// File: tb/tb_block_ram_pipe.sv
// Scoreboard bench: READ_FIRST and WRITE_FIRST instances share one stimulus stream.
module tb_block_ram_pipe;
    import block_ram_pkg::*;

    logic        clk = 1'b0, reset_n = 1'b0, clear_req = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [3:0]  wr_addr = '0, rd_addr = '0, wr_strb = '0;
    logic [31:0] wr_data = '0;
    logic        busy_rf, busy_wf, rv_rf, rv_wf;
    logic [31:0] rd_rf, rd_wf;

    block_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(READ_FIRST)) u_rf (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .busy(busy_rf),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv_rf), .rd_data(rd_rf));

    block_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(WRITE_FIRST)) u_wf (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .busy(busy_wf),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv_wf), .rd_data(rd_wf));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rf;
        logic [31:0] wf;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mdl [16];
    logic [31:0] last_rf = '0, last_wf = '0;
    int          errors = 0, checks = 0, mdl_busy = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // One cycle of stimulus; expected read results are queued with their due cycle.
    task automatic op(input bit we, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                      input bit re, input logic [3:0] ra, input bit clr);
        exp_t e;
        @(negedge clk);
        chk("busy_rf", 32'(busy_rf), 32'(mdl_busy != 0));
        chk("busy_wf", 32'(busy_wf), 32'(mdl_busy != 0));
        wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
        rd_en = re; rd_addr = ra; clear_req = clr;
        if (mdl_busy == 0) begin
            if (re) begin
                e.rf  = mdl[ra];
                e.wf  = (we && wa == ra) ? bmerge(mdl[ra], wd, ws) : mdl[ra];
                e.due = cyc + 2;
                sb.push_back(e);
            end
            if (we) mdl[wa] = bmerge(mdl[wa], wd, ws);
            if (clr) begin
                mdl_busy = 16;
                for (int i = 0; i < 16; i++) mdl[i] = '0;
            end
        end else begin
            mdl_busy--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 0);
    endtask

    task automatic assert_rst();
        @(negedge clk);
        reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
        #1;
        chk("rst_rv_rf", 32'(rv_rf), 32'h0);
        chk("rst_rv_wf", 32'(rv_wf), 32'h0);
        chk("rst_busy", 32'(busy_rf & busy_wf), 32'h1);
        chk("rst_rdata", rd_rf | rd_wf, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    // Release reset at a negedge and count the cycles busy stays high.
    task automatic sweep_check();
        int n = 1;
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_rf) break;
            n++;
        end
        chk("sweep_len", 32'(n), 32'd16);
        chk("sweep_busy_wf", 32'(busy_wf), 32'h0);
        mdl_busy = 0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            sb.delete();
            last_rf = '0; last_wf = '0;
            chk("rv_in_rst", 32'(rv_rf | rv_wf), 32'h0);
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            chk("rv_rf", 32'(rv_rf), 32'h1);
            chk("rv_wf", 32'(rv_wf), 32'h1);
            chk("rdata_rf", rd_rf, mon_e.rf);
            chk("rdata_wf", rd_wf, mon_e.wf);
            last_rf = rd_rf; last_wf = rd_wf;
        end else begin
            chk("no_rv_rf", 32'(rv_rf), 32'h0);
            chk("no_rv_wf", 32'(rv_wf), 32'h0);
            chk("hold_rf", rd_rf, last_rf);
            chk("hold_wf", rd_wf, last_wf);
        end
    end

    initial begin
        assert_rst();
        sweep_check();
        for (int a = 0; a < 16; a++) op(0, 4'h0, 32'h0, 4'h0, 1, 4'(a), 0);
        idle(3);

        op(1, 4'd3, 32'hAABBCCDD, 4'hF, 0, 4'd0, 0);
        op(1, 4'd3, 32'h11223344, 4'h5, 0, 4'd0, 0);
        op(0, 4'd0, 32'h0, 4'h0, 1, 4'd3, 0);
        idle(3);

        op(1, 4'd6, 32'h12345678, 4'hF, 0, 4'd0, 0);
        op(1, 4'd5, 32'hFFFFFFFF, 4'hF, 1, 4'd5, 0);
        op(1, 4'd6, 32'hAABBCCDD, 4'h6, 1, 4'd6, 0);
        op(1, 4'd9, 32'hDEADBEEF, 4'h0, 1, 4'd9, 0);
        op(0, 4'd0, 32'h0, 4'h0, 1, 4'd5, 0);
        idle(3);

        for (int a = 0; a < 16; a++) op(1, 4'(a), $urandom, 4'hF, 0, 4'd0, 0);
        for (int a = 0; a < 16; a++) op(0, 4'd0, 32'h0, 4'h0, 1, 4'(a), 0);
        for (int a = 0; a < 16; a++) op(1, 4'(a), $urandom, 4'($urandom), 1, 4'(15 - a), 0);
        idle(3);

        // Clear with a read in flight, traffic and a repeat clear_req while busy.
        op(0, 4'd0, 32'h0, 4'h0, 1, 4'd3, 1);
        for (int i = 0; i < 16; i++) op(1, 4'(i), $urandom, 4'hF, 1, 4'(i), (i == 4) ? 1'b1 : 1'b0);
        for (int a = 0; a < 16; a++) op(0, 4'd0, 32'h0, 4'h0, 1, 4'(a), 0);
        idle(3);

        op(1, 4'd2, 32'hCAFEF00D, 4'hF, 1, 4'd2, 0);
        op(0, 4'd0, 32'h0, 4'h0, 1, 4'd2, 0);
        assert_rst();
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midsweep_busy", 32'(busy_rf), 32'h1);
        assert_rst();
        sweep_check();
        for (int a = 0; a < 16; a++) op(0, 4'd0, 32'h0, 4'h0, 1, 4'(a), 0);
        idle(4);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
